// File: rtl/text_console_writer.sv
// Text console writer: turns a stream of character codes into text-RAM writes,
// tracking a cursor and scrolling the screen through a circular row offset.
module text_console_writer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter logic [7:0]  BLANK_ATTR = 8'h0F
) (
    input  logic        CLOCK_CORE,
    input  logic        RESET,
    input  logic [7:0]  CHAR_IN,
    input  logic [7:0]  ATTR_IN,
    input  logic        CHAR_VALID,
    output logic        CHAR_READY,
    input  logic        CLEAR,
    output logic [12:0] WR_ADDRESS,
    output logic [7:0]  WR_CHAR_DATA,
    output logic [7:0]  WR_ATTR_DATA,
    output logic        WR_CHAR_WE,
    output logic        WR_ATTR_WE,
    output logic [7:0]  RAM_ROW_OFFSET,
    output logic [6:0]  CURSOR_COL,
    output logic [5:0]  CURSOR_ROW,
    output logic        BUSY
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_DEL = 8'h7F;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_SCREEN = 2'd1,
        CLR_ROW    = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  offset_r;
    logic [6:0]  cursor_col_r;
    logic [5:0]  cursor_row_r;
    logic [6:0]  clr_col_r;
    logic [5:0]  clr_row_r;
    logic        clear_pend_r;
    logic [12:0] wr_addr_r;
    logic [7:0]  wr_char_r;
    logic [7:0]  wr_attr_r;
    logic        wr_we_r;

    logic        is_print_s;
    logic        newline_s;
    logic        clear_req_s;
    logic        start_clr_s;

    // Logical row to physical RAM row; the 6-bit sum wraps modulo 64.
    function automatic logic [5:0] phys_row(input logic [5:0] lrow, input logic [5:0] off);
        return lrow + off;
    endfunction

    // Decode the incoming code and decide whether a screen clear starts this cycle.
    always_comb begin
        is_print_s  = (CHAR_IN >= 8'h20) && (CHAR_IN != CODE_DEL);
        newline_s   = (is_print_s && (cursor_col_r == LAST_COL)) || (CHAR_IN == CODE_LF);
        clear_req_s = clear_pend_r || CLEAR;
        case (state_r)
            IDLE:       start_clr_s = CLEAR || (CHAR_VALID && (CHAR_IN == CODE_FF));
            CLR_SCREEN: start_clr_s = clear_req_s && (clr_row_r == LAST_ROW) && (clr_col_r == LAST_COL);
            CLR_ROW:    start_clr_s = clear_req_s && (clr_col_r == LAST_COL);
            default:    start_clr_s = 1'b0;
        endcase
    end

    // Main state machine: cursor, offset, clear sequencing and registered RAM writes.
    always_ff @(posedge CLOCK_CORE) begin
        if (RESET) begin
            state_r      <= CLR_SCREEN;
            offset_r     <= 6'd0;
            cursor_col_r <= 7'd0;
            cursor_row_r <= 6'd0;
            clr_col_r    <= 7'd0;
            clr_row_r    <= 6'd0;
            clear_pend_r <= 1'b0;
            wr_addr_r    <= 13'd0;
            wr_char_r    <= 8'd0;
            wr_attr_r    <= 8'd0;
            wr_we_r      <= 1'b0;
        end else begin
            wr_we_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!start_clr_s && CHAR_VALID) begin
                        if (is_print_s) begin
                            wr_addr_r    <= {phys_row(cursor_row_r, offset_r), cursor_col_r};
                            wr_char_r    <= CHAR_IN;
                            wr_attr_r    <= ATTR_IN;
                            wr_we_r      <= 1'b1;
                            cursor_col_r <= cursor_col_r + 7'd1;
                        end else if (CHAR_IN == CODE_CR) begin
                            cursor_col_r <= 7'd0;
                        end else if ((CHAR_IN == CODE_BS) && (cursor_col_r != 7'd0)) begin
                            cursor_col_r <= cursor_col_r - 7'd1;
                        end
                        // A newline on the bottom row scrolls and blanks the new bottom row.
                        if (newline_s) begin
                            cursor_col_r <= 7'd0;
                            if (cursor_row_r == LAST_ROW) begin
                                offset_r  <= offset_r + 6'd1;
                                clr_col_r <= 7'd0;
                                state_r   <= CLR_ROW;
                            end else begin
                                cursor_row_r <= cursor_row_r + 6'd1;
                            end
                        end
                    end
                end
                CLR_SCREEN: begin
                    wr_addr_r <= {phys_row(clr_row_r, offset_r), clr_col_r};
                    wr_char_r <= BLANK_CHAR;
                    wr_attr_r <= BLANK_ATTR;
                    wr_we_r   <= 1'b1;
                    if (CLEAR) begin
                        clear_pend_r <= 1'b1;
                    end
                    if (clr_col_r == LAST_COL) begin
                        clr_col_r <= 7'd0;
                        if (clr_row_r == LAST_ROW) begin
                            state_r <= IDLE;
                        end else begin
                            clr_row_r <= clr_row_r + 6'd1;
                        end
                    end else begin
                        clr_col_r <= clr_col_r + 7'd1;
                    end
                end
                CLR_ROW: begin
                    wr_addr_r <= {phys_row(LAST_ROW, offset_r), clr_col_r};
                    wr_char_r <= BLANK_CHAR;
                    wr_attr_r <= BLANK_ATTR;
                    wr_we_r   <= 1'b1;
                    if (CLEAR) begin
                        clear_pend_r <= 1'b1;
                    end
                    if (clr_col_r == LAST_COL) begin
                        clr_col_r <= 7'd0;
                        state_r   <= IDLE;
                    end else begin
                        clr_col_r <= clr_col_r + 7'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // A clear (fresh or pending) overrides whatever the case above chose.
            if (start_clr_s) begin
                state_r      <= CLR_SCREEN;
                clr_col_r    <= 7'd0;
                clr_row_r    <= 6'd0;
                cursor_col_r <= 7'd0;
                cursor_row_r <= 6'd0;
                clear_pend_r <= 1'b0;
            end
        end
    end

    assign CHAR_READY     = (state_r == IDLE) && !CLEAR && !RESET;
    assign BUSY           = (state_r != IDLE);
    assign WR_ADDRESS     = wr_addr_r;
    assign WR_CHAR_DATA   = wr_char_r;
    assign WR_ATTR_DATA   = wr_attr_r;
    assign WR_CHAR_WE     = wr_we_r;
    assign WR_ATTR_WE     = wr_we_r;
    assign RAM_ROW_OFFSET = {2'b00, offset_r};
    assign CURSOR_COL     = cursor_col_r;
    assign CURSOR_ROW     = cursor_row_r;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table for single codes plus
// hand-written sequences for clears, scrolling, offset wrap and reset abort.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic [7:0]  attr_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear = 1'b0;
    logic [12:0] wr_address;
    logic [7:0]  wr_char_data;
    logic [7:0]  wr_attr_data;
    logic        wr_char_we;
    logic        wr_attr_we;
    logic [7:0]  ram_row_offset;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console_writer dut (
        .CLOCK_CORE     (clk),
        .RESET          (rst),
        .CHAR_IN        (char_in),
        .ATTR_IN        (attr_in),
        .CHAR_VALID     (char_valid),
        .CHAR_READY     (char_ready),
        .CLEAR          (clear),
        .WR_ADDRESS     (wr_address),
        .WR_CHAR_DATA   (wr_char_data),
        .WR_ATTR_DATA   (wr_attr_data),
        .WR_CHAR_WE     (wr_char_we),
        .WR_ATTR_WE     (wr_attr_we),
        .RAM_ROW_OFFSET (ram_row_offset),
        .CURSOR_COL     (cursor_col),
        .CURSOR_ROW     (cursor_row),
        .BUSY           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  ch;
        logic [7:0]  at;
        logic        we;
        logic [12:0] addr;
        logic [6:0]  col;
        logic [5:0]  row;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write port as one vector: {char_we, attr_we, address, char, attr}.
    function automatic logic [63:0] wr_bus();
        return {26'd0, wr_char_we, wr_attr_we, wr_address, wr_char_data, wr_attr_data};
    endfunction

    function automatic logic [63:0] exp_wr(input int prow, input int col, input logic [7:0] c, input logic [7:0] a);
        logic [5:0] pr;
        logic [6:0] cl;
        pr = 6'(prow % 64);
        cl = 7'(col);
        return {26'd0, 1'b1, 1'b1, pr, cl, c, a};
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        check("ready_before_send", {63'd0, char_ready}, 64'd1);
        char_in    = c;
        attr_in    = a;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic chk_clr_screen(input int off);
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                tick();
                check("clr_screen_write", wr_bus(), exp_wr(r + off, c, 8'h20, 8'h0F));
                if (r == 0 && c == 0) check("clr_screen_ready", {63'd0, char_ready}, 64'd0);
            end
        end
        check("clr_screen_busy_end", {63'd0, busy}, 64'd0);
        check("clr_screen_ready_end", {63'd0, char_ready}, 64'd1);
        check("clr_screen_cursor", {51'd0, cursor_row, cursor_col}, 64'd0);
    endtask

    task automatic chk_clr_row(input int prow, input int pa, input int pb);
        for (int i = 0; i < 80; i++) begin
            clear = (i == pa) || (i == pb);
            tick();
            clear = 1'b0;
            check("clr_row_write", wr_bus(), exp_wr(prow, i, 8'h20, 8'h0F));
            if (i < 79) check("clr_row_busy", {63'd0, busy}, 64'd1);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h41, 8'h1E, 1'b1, 13'd0,   7'd1, 6'd0};
        vecs[1]  = '{8'h42, 8'h07, 1'b1, 13'd1,   7'd2, 6'd0};
        vecs[2]  = '{8'h08, 8'h00, 1'b0, 13'd0,   7'd1, 6'd0};
        vecs[3]  = '{8'h0D, 8'h00, 1'b0, 13'd0,   7'd0, 6'd0};
        vecs[4]  = '{8'h08, 8'h00, 1'b0, 13'd0,   7'd0, 6'd0};
        vecs[5]  = '{8'h0A, 8'h00, 1'b0, 13'd0,   7'd0, 6'd1};
        vecs[6]  = '{8'h7F, 8'h00, 1'b0, 13'd0,   7'd0, 6'd1};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 13'd0,   7'd0, 6'd1};
        vecs[8]  = '{8'h80, 8'h55, 1'b1, 13'd128, 7'd1, 6'd1};
        vecs[9]  = '{8'hFF, 8'hAA, 1'b1, 13'd129, 7'd2, 6'd1};
        vecs[10] = '{8'h20, 8'h33, 1'b1, 13'd130, 7'd3, 6'd1};
        vecs[11] = '{8'h7E, 8'h44, 1'b1, 13'd131, 7'd4, 6'd1};
        vecs[12] = '{8'h1B, 8'h00, 1'b0, 13'd0,   7'd4, 6'd1};

        // Reset state, then the post-reset screen clear.
        repeat (3) tick();
        check("rst_we", {63'd0, wr_char_we}, 64'd0);
        check("rst_offset", {56'd0, ram_row_offset}, 64'd0);
        check("rst_cursor", {51'd0, cursor_row, cursor_col}, 64'd0);
        check("rst_ready", {63'd0, char_ready}, 64'd0);
        rst = 1'b0;
        chk_clr_screen(0);

        // Single-code vector table.
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].ch, vecs[i].at);
            check("vec_we", {62'd0, wr_char_we, wr_attr_we}, {62'd0, vecs[i].we, vecs[i].we});
            if (vecs[i].we)
                check("vec_write", {23'd0, wr_address, wr_char_data, wr_attr_data},
                      {23'd0, vecs[i].addr, vecs[i].ch, vecs[i].at});
            check("vec_cursor", {51'd0, cursor_row, cursor_col}, {51'd0, vecs[i].row, vecs[i].col});
        end

        // Fill row 5 with 80 back-to-back characters; wraps to (0,6).
        repeat (4) send(8'h0A, 8'h00);
        char_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            char_in = 8'(8'h21 + i);
            attr_in = 8'(i);
            tick();
            check("row_fill_write", wr_bus(), exp_wr(5, i, 8'(8'h21 + i), 8'(i)));
        end
        char_valid = 1'b0;
        check("row_fill_cursor", {51'd0, cursor_row, cursor_col}, {51'd0, 6'd6, 7'd0});

        // LF on the last row scrolls; CHAR_VALID held during the row blank.
        repeat (23) send(8'h0A, 8'h00);
        check("at_last_row", {58'd0, cursor_row}, 64'd29);
        send(8'h0A, 8'h00);
        char_in = 8'h5A;
        char_valid = 1'b1;
        check("scroll_offset", {56'd0, ram_row_offset}, 64'd1);
        check("scroll_cursor", {51'd0, cursor_row, cursor_col}, {51'd0, 6'd29, 7'd0});
        check("scroll_lf_nowrite", {63'd0, wr_char_we}, 64'd0);
        check("scroll_busy", {63'd0, busy}, 64'd1);
        chk_clr_row(30, -1, -1);
        check("scroll_busy_end", {63'd0, busy}, 64'd0);
        char_valid = 1'b0;
        check("scroll_cursor_end", {51'd0, cursor_row, cursor_col}, {51'd0, 6'd29, 7'd0});

        // Two CLEAR pulses during a row blank collapse into one full clear.
        send(8'h0A, 8'h00);
        char_in = 8'h41;
        char_valid = 1'b1;
        check("scroll2_offset", {56'd0, ram_row_offset}, 64'd2);
        chk_clr_row(31, 10, 40);
        check("pending_clear_busy", {63'd0, busy}, 64'd1);
        chk_clr_screen(2);
        char_valid = 1'b0;
        check("clear_keeps_offset", {56'd0, ram_row_offset}, 64'd2);
        tick();
        check("clear_collapsed_busy", {63'd0, busy}, 64'd0);
        check("clear_collapsed_we", {63'd0, wr_char_we}, 64'd0);

        // Form feed behaves as a clear.
        send(8'h51, 8'h11);
        check("q_write", wr_bus(), exp_wr(2, 0, 8'h51, 8'h11));
        send(8'h0C, 8'h00);
        check("ff_nowrite", {63'd0, wr_char_we}, 64'd0);
        check("ff_busy", {63'd0, busy}, 64'd1);
        chk_clr_screen(2);

        // CLEAR and CHAR_VALID together: clear wins.
        send(8'h51, 8'h11);
        clear = 1'b1;
        char_in = 8'h58;
        char_valid = 1'b1;
        #1;
        check("clear_vs_char_ready", {63'd0, char_ready}, 64'd0);
        tick();
        clear = 1'b0;
        char_valid = 1'b0;
        check("clear_vs_char_nowrite", {63'd0, wr_char_we}, 64'd0);
        check("clear_vs_char_cursor", {51'd0, cursor_row, cursor_col}, 64'd0);
        chk_clr_screen(2);

        // Scroll until the offset wraps 63 -> 0.
        repeat (29) send(8'h0A, 8'h00);
        for (int s = 0; s < 62; s++) begin
            send(8'h0A, 8'h00);
            check("wrap_offset", {56'd0, ram_row_offset}, 64'((3 + s) % 64));
            chk_clr_row((32 + s) % 64, -1, -1);
        end
        check("wrap_offset_zero", {56'd0, ram_row_offset}, 64'd0);

        // Reset in the middle of a row blank restarts the full clear.
        send(8'h0A, 8'h00);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_offset", {56'd0, ram_row_offset}, 64'd0);
        check("midrst_we", {63'd0, wr_char_we}, 64'd0);
        check("midrst_cursor", {51'd0, cursor_row, cursor_col}, 64'd0);
        check("midrst_ready", {63'd0, char_ready}, 64'd0);
        tick();
        rst = 1'b0;
        chk_clr_screen(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 80; characters per row; legal range 1-128.
REQ-002 Parameter ROWS, default 30; visible rows; legal range 1-64.
REQ-003 Parameter BLANK_CHAR, default 8'h20; codepoint written when clearing.
REQ-004 Parameter BLANK_ATTR, default 8'h0F; attribute written when clearing.
REQ-005 CLOCK_CORE input 1; sole clock; all logic on its rising edge.
REQ-006 RESET input 1; synchronous, active-high.
REQ-007 CHAR_IN input 8; codepoint or control code.
REQ-008 ATTR_IN input 8; attribute paired with CHAR_IN.
REQ-009 CHAR_VALID input 1; CHAR_IN/ATTR_IN valid.
REQ-010 CHAR_READY output 1; writer accepts this cycle.
REQ-011 CLEAR input 1; single-cycle clear-screen request.
REQ-012 WR_ADDRESS output 13; text RAM address {phys_row[5:0], col[6:0]}.
REQ-013 WR_CHAR_DATA output 8; codepoint write data.
REQ-014 WR_ATTR_DATA output 8; attribute write data.
REQ-015 WR_CHAR_WE output 1; character RAM write strobe.
REQ-016 WR_ATTR_WE output 1; attribute RAM write strobe, always equal to WR_CHAR_WE.
REQ-017 RAM_ROW_OFFSET output 8; first visible physical row, drives the display's row offset; bits [7:6] always 0.
REQ-018 CURSOR_COL output 7; cursor column, 0..COLS-1.
REQ-019 CURSOR_ROW output 6; cursor logical row, 0..ROWS-1.
REQ-020 BUSY output 1; high in any state other than IDLE.

Function
REQ-021 State machine states: IDLE, CLR_SCREEN, CLR_ROW.
REQ-022 CHAR_READY = (state==IDLE) && !CLEAR && !RESET; combinational.
REQ-023 A transfer occurs on a rising edge with CHAR_VALID && CHAR_READY.
REQ-024 phys_row = (logical_row + RAM_ROW_OFFSET) mod 64, 6-bit wrap.
REQ-025 All write outputs are registered; a write occurs exactly 1 cycle after its accepting edge and lasts one cycle.
REQ-026 Printable code (0x20-0x7E, 0x80-0xFF) -> write CHAR_IN/ATTR_IN at the current cursor position, then advance the cursor.
REQ-027 Advance: col<COLS-1 -> col+1; col==COLS-1 -> newline.
REQ-028 Newline: col=0; row<ROWS-1 -> row+1; row==ROWS-1 -> scroll.
REQ-029 Scroll: RAM_ROW_OFFSET <= (offset+1) mod 64; row stays ROWS-1; enter CLR_ROW.
REQ-030 CLR_ROW: COLS consecutive cycles writing BLANK_CHAR/BLANK_ATTR to cols 0..COLS-1 of logical row ROWS-1, using the new offset; then IDLE.
REQ-031 0x0A (LF) -> newline, no write.
REQ-032 0x0D (CR) -> col=0, no write.
REQ-033 0x08 (BS) -> col>0 ? col-1 : unchanged; no write.
REQ-034 0x0C (FF) -> same as CLEAR.
REQ-035 Other control codes (0x00-0x1F not listed, 0x7F) -> accepted and discarded.
REQ-036 Clear: enter CLR_SCREEN; write blanks to all ROWS*COLS cells, row-major from logical (0,0); offset unchanged; cursor (0,0); then IDLE.
REQ-037 CLEAR asserted while BUSY -> latched; clear starts on the cycle after the current operation completes; multiple pulses collapse into one clear.
REQ-038 CLEAR and CHAR_VALID in the same IDLE cycle -> clear wins; character not accepted.
REQ-039 CURSOR_COL/CURSOR_ROW reflect post-operation values on the edge after acceptance.

Reset
REQ-040 RESET -> offset 0, cursor (0,0), pending clear dropped, write strobes low; state CLR_SCREEN on release.
REQ-041 RESET mid-operation aborts the operation; the clear restarts from (0,0).
REQ-042 Post-reset clear takes ROWS*COLS cycles (2400 default); CHAR_READY stays low until it completes.

Verification
REQ-043 Reset release -> 2400 blank writes, addresses {row,col} rows 0-29, cols 0-79; BUSY then low; CHAR_READY high.
REQ-044 Send 'A' (0x41, attr 0x1E) at (0,0) -> next cycle WR_ADDRESS=0, data 0x41/0x1E, both WE high; CURSOR_COL=1.
REQ-045 Send 80 printable characters from col 0, row 5 -> last write at col 79; cursor (0,6).
REQ-046 Cursor at row 29, send LF -> RAM_ROW_OFFSET 0->1; 80 blank writes to phys_row 30; cursor (0,29); BUSY 80 cycles.
REQ-047 Offset 63, scroll -> offset 0; blank row at phys_row (29+0) mod 64 = 29.
REQ-048 CLEAR pulsed during CLR_ROW -> CLR_ROW finishes, then 2400-cycle clear; CHAR_VALID held high meanwhile is not accepted.
